// File: rtl/biquad_capture_sequencer.sv
// Capture sequencer for a biquad filter path: pre-gate delay, gated capture,
// post-gate settle and a biquad flush, started by a rising edge on capture_i.
module biquad_capture_sequencer #(
  parameter int unsigned CNT_BITS  = 8,
  parameter int unsigned DEF_PRE   = 32,
  parameter int unsigned DEF_GATE  = 64,
  parameter int unsigned DEF_POST  = 64,
  parameter int unsigned DEF_FLUSH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                capture_i,
  input  logic                cfg_we_i,
  input  logic [1:0]          cfg_sel_i,
  input  logic [CNT_BITS-1:0] cfg_len_i,
  input  logic                ovr_clr_i,
  output logic                gate_o,
  output logic                bq_rst_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [7:0]          ovr_cnt_o
);

  typedef enum logic [2:0] {IDLE, PRE, GATE, POST, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_BITS-1:0] len_q [4];
  logic [CNT_BITS-1:0] sh_gate_q, sh_post_q, sh_flush_q;
  logic                cap_q, rise, start, overrun;
  logic                done_q, done_d;
  logic [7:0]          ovr_q;

  // A zero length still occupies one cycle, so it reloads the same as one.
  function automatic logic [CNT_BITS-1:0] reload(input logic [CNT_BITS-1:0] len);
    return (len == '0) ? '0 : len - CNT_BITS'(1);
  endfunction

  assign rise    = capture_i & ~cap_q;
  assign overrun = rise && ((state_q != IDLE) || done_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise && !done_q) begin
          start   = 1'b1;
          state_d = PRE;
          cnt_d   = reload(len_q[0]);
        end
      end
      PRE: begin
        if (cnt_q == '0) begin
          state_d = GATE;
          cnt_d   = reload(sh_gate_q);
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      GATE: begin
        if (cnt_q == '0) begin
          state_d = POST;
          cnt_d   = reload(sh_post_q);
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      POST: begin
        if (cnt_q == '0) begin
          state_d = FLUSH;
          cnt_d   = reload(sh_flush_q);
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      // Treat capture as already high so a level held through reset cannot start.
      cap_q      <= 1'b1;
      done_q     <= 1'b0;
      ovr_q      <= '0;
      len_q[0]   <= CNT_BITS'(DEF_PRE);
      len_q[1]   <= CNT_BITS'(DEF_GATE);
      len_q[2]   <= CNT_BITS'(DEF_POST);
      len_q[3]   <= CNT_BITS'(DEF_FLUSH);
      sh_gate_q  <= CNT_BITS'(DEF_GATE);
      sh_post_q  <= CNT_BITS'(DEF_POST);
      sh_flush_q <= CNT_BITS'(DEF_FLUSH);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= capture_i;
      done_q  <= done_d;
      if (cfg_we_i) begin
        len_q[cfg_sel_i] <= cfg_len_i;
      end
      // PRE length goes straight into the counter; the rest are shadowed here.
      if (start) begin
        sh_gate_q  <= len_q[1];
        sh_post_q  <= len_q[2];
        sh_flush_q <= len_q[3];
      end
      if (ovr_clr_i) begin
        ovr_q <= '0;
      end else if (overrun && (ovr_q != '1)) begin
        ovr_q <= ovr_q + 8'd1;
      end
    end
  end

  assign gate_o    = (state_q == GATE);
  assign bq_rst_o  = (state_q == FLUSH);
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign ovr_cnt_o = ovr_q;

endmodule

// File: tb/tb_biquad_capture_sequencer.sv
// Directed bench for biquad_capture_sequencer: phase placement, overruns,
// config shadowing and reset behaviour, checked against hand-computed cycles.
module tb_biquad_capture_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i, capture_i, cfg_we_i, ovr_clr_i;
  logic [1:0] cfg_sel_i;
  logic [7:0] cfg_len_i;
  logic       gate_o, bq_rst_o, busy_o, done_o;
  logic [7:0] ovr_cnt_o;

  int nvec = 0;
  int nerr = 0;
  int bf, gf, gl, gc, rf, rl, dn, bad;
  logic busy_at_done;

  biquad_capture_sequencer #(
    .CNT_BITS (8),
    .DEF_PRE  (32),
    .DEF_GATE (64),
    .DEF_POST (64),
    .DEF_FLUSH(32)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .capture_i(capture_i),
    .cfg_we_i (cfg_we_i),
    .cfg_sel_i(cfg_sel_i),
    .cfg_len_i(cfg_len_i),
    .ovr_clr_i(ovr_clr_i),
    .gate_o   (gate_o),
    .bq_rst_o (bq_rst_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .ovr_cnt_o(ovr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] len);
    cfg_we_i  = 1'b1;
    cfg_sel_i = sel;
    cfg_len_i = len;
    tick();
    cfg_we_i  = 1'b0;
  endtask

  // Start at edge T; index i is the cycle T+i. Stops at the done_o cycle.
  task automatic measure(input int maxc, input int pulse_at, input int cfgw_at,
                         input logic [1:0] sel, input logic [7:0] len);
    bf = -1; gf = -1; gl = -1; gc = 0; rf = -1; rl = -1; dn = -1;
    busy_at_done = 1'b1;
    cfg_sel_i = sel;
    cfg_len_i = len;
    capture_i = 1'b1;
    cfg_we_i  = (cfgw_at == 0);
    tick();
    for (int i = 1; i <= maxc; i++) begin
      if (busy_o && bf < 0) bf = i;
      if (gate_o) begin
        if (gf < 0) gf = i;
        gl = i;
        gc++;
      end
      if (bq_rst_o) begin
        if (rf < 0) rf = i;
        rl = i;
      end
      if (done_o) begin
        dn = i;
        busy_at_done = busy_o;
        break;
      end
      capture_i = (i == pulse_at);
      cfg_we_i  = (i == cfgw_at);
      tick();
    end
    capture_i = 1'b0;
    cfg_we_i  = 1'b0;
  endtask

  task automatic chk_default(input string tag);
    chk({tag, ".busy_first"}, bf, 1);
    chk({tag, ".gate_first"}, gf, 33);
    chk({tag, ".gate_last"},  gl, 96);
    chk({tag, ".gate_cnt"},   gc, 64);
    chk({tag, ".bq_first"},   rf, 161);
    chk({tag, ".bq_last"},    rl, 192);
    chk({tag, ".done_at"},    dn, 193);
    chk({tag, ".busy_at_done"}, int'(busy_at_done), 0);
  endtask

  initial begin
    rst_i = 1'b1; capture_i = 1'b0; cfg_we_i = 1'b0; ovr_clr_i = 1'b0;
    cfg_sel_i = '0; cfg_len_i = '0;
    repeat (3) tick();
    chk("rst.gate", int'(gate_o), 0);
    chk("rst.bq",   int'(bq_rst_o), 0);
    chk("rst.busy", int'(busy_o), 0);
    chk("rst.done", int'(done_o), 0);
    chk("rst.ovr",  int'(ovr_cnt_o), 0);
    rst_i = 1'b0;
    tick();

    // Default lengths, single start
    measure(300, -1, -1, 2'd0, 8'd0);
    chk_default("seq1");
    chk("seq1.ovr", int'(ovr_cnt_o), 0);

    // Start on the cycle after done, with a dropped edge at T+50
    tick();
    measure(300, 50, -1, 2'd0, 8'd0);
    chk_default("seq2");
    chk("seq2.ovr", int'(ovr_cnt_o), 1);

    // Edge presented during the done cycle is dropped
    capture_i = 1'b1;
    tick();
    chk("donecyc.busy", int'(busy_o), 0);
    chk("donecyc.ovr",  int'(ovr_cnt_o), 2);
    capture_i = 1'b0;
    tick();

    // Minimum lengths; GATE=10 written mid-sequence
    wr(2'd0, 8'd0); wr(2'd1, 8'd1); wr(2'd2, 8'd0); wr(2'd3, 8'd0);
    measure(50, -1, 2, 2'd1, 8'd10);
    chk("seq3.gate_first", gf, 2);
    chk("seq3.gate_cnt",   gc, 1);
    chk("seq3.bq_first",   rf, 4);
    chk("seq3.bq_last",    rl, 4);
    chk("seq3.done_at",    dn, 5);

    // GATE=10 now live; GATE=3 written on the start edge must not be shadowed
    tick();
    measure(50, -1, 0, 2'd1, 8'd3);
    chk("seq4.gate_first", gf, 2);
    chk("seq4.gate_last",  gl, 11);
    chk("seq4.gate_cnt",   gc, 10);
    chk("seq4.bq_first",   rf, 13);
    chk("seq4.done_at",    dn, 14);

    tick();
    measure(50, -1, -1, 2'd0, 8'd0);
    chk("seq5.gate_cnt", gc, 3);
    chk("seq5.gate_last", gl, 4);
    chk("seq5.done_at",  dn, 7);

    // Overrun saturation inside a long sequence
    tick();
    wr(2'd0, 8'd255); wr(2'd1, 8'd255); wr(2'd2, 8'd255); wr(2'd3, 8'd255);
    capture_i = 1'b1; tick();
    capture_i = 1'b0; tick();
    for (int k = 0; k < 300; k++) begin
      capture_i = 1'b1; tick();
      capture_i = 1'b0; tick();
    end
    chk("sat.busy", int'(busy_o), 1);
    chk("sat.ovr",  int'(ovr_cnt_o), 255);
    capture_i = 1'b1; ovr_clr_i = 1'b1; tick();
    chk("clr.ovr", int'(ovr_cnt_o), 0);
    capture_i = 1'b0; ovr_clr_i = 1'b0; tick();
    capture_i = 1'b1; tick();
    chk("ovr_after_clr", int'(ovr_cnt_o), 1);
    capture_i = 1'b0;

    // Reset mid-gate with capture held high through release
    rst_i = 1'b1; tick(); rst_i = 1'b0; tick();
    capture_i = 1'b1; tick();
    capture_i = 1'b0; tick();
    capture_i = 1'b1; tick();
    capture_i = 1'b0;
    chk("midrst.pre_ovr", int'(ovr_cnt_o), 1);
    for (int k = 0; k < 100 && !gate_o; k++) tick();
    chk("midrst.gate_seen", int'(gate_o), 1);
    rst_i = 1'b1; capture_i = 1'b1; tick();
    chk("midrst.gate", int'(gate_o), 0);
    chk("midrst.bq",   int'(bq_rst_o), 0);
    chk("midrst.busy", int'(busy_o), 0);
    chk("midrst.done", int'(done_o), 0);
    chk("midrst.ovr",  int'(ovr_cnt_o), 0);
    tick();
    rst_i = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (busy_o || done_o) bad++;
    end
    chk("held_capture.no_start", bad, 0);
    capture_i = 1'b0;
    tick();
    measure(300, -1, -1, 2'd0, 8'd0);
    chk_default("seq_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
